// File: rtl/if_stage.sv
// Instruction-fetch stage: holds the architectural PC, addresses instruction
// memory and registers the fetched word into the IF/ID pipeline register.
// Redirect priority: EX taken branch > stall > ID jump > sequential fetch.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        ex_branch_taken,
    input  logic [31:0] ex_branch_target,
    input  logic        id_jump,
    input  logic [31:0] id_jump_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [31:0] fetch_count,
    output logic        misaligned
);

    typedef enum logic [1:0] {
        SEL_SEQ,
        SEL_BRANCH,
        SEL_HOLD,
        SEL_JUMP
    } sel_t;

    sel_t        sel;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_raw;
    logic [31:0] redirect_pc;
    logic        redirect_bad;

    // Fetch address is the PC itself; the only combinational output path.
    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;

    // Next-PC source selection; a branch outranks a stall because the branch
    // is older than the stalled ID instruction.
    always_comb begin
        sel          = SEL_SEQ;
        redirect_raw = '0;
        if (ex_branch_taken) begin
            sel          = SEL_BRANCH;
            redirect_raw = ex_branch_target;
        end else if (stall) begin
            sel = SEL_HOLD;
        end else if (id_jump) begin
            sel          = SEL_JUMP;
            redirect_raw = id_jump_target;
        end
        redirect_pc  = {redirect_raw[31:2], 2'b00};
        redirect_bad = |redirect_raw[1:0];
    end

    // PC, IF/ID register, retired-fetch counter and sticky misalignment flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            if_id_instr <= NOP_WORD;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
            fetch_count <= '0;
            misaligned  <= 1'b0;
        end else begin
            case (sel)
                SEL_BRANCH, SEL_JUMP: begin
                    pc          <= redirect_pc;
                    if_id_instr <= NOP_WORD;
                    if_id_pc4   <= '0;
                    if_id_valid <= 1'b0;
                    if (redirect_bad) begin
                        misaligned <= 1'b1;
                    end
                end
                SEL_HOLD: begin
                    pc          <= pc;
                    if_id_instr <= if_id_instr;
                    if_id_pc4   <= if_id_pc4;
                    if_id_valid <= if_id_valid;
                end
                default: begin
                    pc          <= pc_plus4;
                    if_id_instr <= imem_rdata;
                    if_id_pc4   <= pc_plus4;
                    if_id_valid <= 1'b1;
                    fetch_count <= fetch_count + 32'd1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: each step pushes the expected IF state to a
// scoreboard queue, which is popped and compared one cycle later.
module tb_if_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        ex_branch_taken;
    logic [31:0] ex_branch_target;
    logic        id_jump;
    logic [31:0] id_jump_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [31:0] fetch_count;
    logic        misaligned;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [31:0] cnt;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    // Expected stage state, advanced from the stimulus alone.
    logic [31:0] m_pc    = 32'h0;
    logic [31:0] m_instr = 32'h0;
    logic [31:0] m_pc4   = 32'h0;
    logic        m_valid = 1'b0;
    logic [31:0] m_cnt   = 32'h0;
    logic        m_mis   = 1'b0;

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_WORD (32'h0000_0000)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .ex_branch_taken  (ex_branch_taken),
        .ex_branch_target (ex_branch_target),
        .id_jump          (id_jump),
        .id_jump_target   (id_jump_target),
        .imem_addr        (imem_addr),
        .imem_rdata       (imem_rdata),
        .pc               (pc),
        .if_id_instr      (if_id_instr),
        .if_id_pc4        (if_id_pc4),
        .if_id_valid      (if_id_valid),
        .fetch_count      (fetch_count),
        .misaligned       (misaligned)
    );

    // imem word index i holds 32'h2000_0000 + i
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'h2000_0000 + {2'b00, a[31:2]};
    endfunction

    assign imem_rdata = word_at(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    // Drive one cycle of inputs, predict the result, clock, then compare.
    task automatic step(input logic rst, input logic stl, input logic br,
                        input logic [31:0] brt, input logic jmp, input logic [31:0] jt);
        exp_t e;
        reset            = rst;
        stall            = stl;
        ex_branch_taken  = br;
        ex_branch_target = brt;
        id_jump          = jmp;
        id_jump_target   = jt;
        if (rst) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
            m_valid = 1'b0; m_cnt = 32'h0; m_mis = 1'b0;
        end else if (br || (!stl && jmp)) begin
            logic [31:0] t;
            t = br ? brt : jt;
            m_pc = {t[31:2], 2'b00};
            m_mis = m_mis | (t[1:0] != 2'b00);
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (!stl) begin
            m_instr = word_at(m_pc);
            m_pc    = m_pc + 32'd4;
            m_pc4   = m_pc;
            m_valid = 1'b1;
            m_cnt   = m_cnt + 32'd1;
        end
        e = '{pc: m_pc, instr: m_instr, pc4: m_pc4, valid: m_valid, cnt: m_cnt, mis: m_mis};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("pc",          pc,                  e.pc);
        chk("imem_addr",   imem_addr,           e.pc);
        chk("if_id_instr", if_id_instr,         e.instr);
        chk("if_id_pc4",   if_id_pc4,           e.pc4);
        chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, e.valid});
        chk("fetch_count", fetch_count,         e.cnt);
        chk("misaligned",  {31'b0, misaligned},  {31'b0, e.mis});
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; ex_branch_taken = 1'b0; ex_branch_target = '0;
        id_jump = 1'b0; id_jump_target = '0;
        #1;

        // reset, with noisy inputs that must be overridden
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h123, 1'b1, 32'h77);
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", {31'b0, if_id_valid}, 32'h0);

        // first fetch after reset
        run(1);
        chk("first_instr", if_id_instr, 32'h2000_0000);
        chk("first_pc4", if_id_pc4, 32'h4);
        run(1);
        chk("pc8", pc, 32'h8);

        // stall two cycles at pc=8, with an ignored jump
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h100);
        chk("stall_pc", pc, 32'h8);
        chk("stall_instr", if_id_instr, 32'h2000_0001);
        chk("stall_cnt", fetch_count, 32'd2);
        run(1);
        chk("resume_pc", pc, 32'd12);
        chk("resume_instr", if_id_instr, 32'h2000_0002);
        chk("resume_cnt", fetch_count, 32'd3);
        run(1);

        // jump at pc=16 to 0x40
        chk("pre_jump_pc", pc, 32'd16);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40);
        chk("jump_pc", pc, 32'h40);
        chk("jump_bubble", if_id_instr, 32'h0);
        run(1);
        chk("jump_instr", if_id_instr, 32'h2000_0010);
        chk("jump_pc4", if_id_pc4, 32'h44);

        // branch beats stall and jump in the same cycle
        step(1'b0, 1'b1, 1'b1, 32'h80, 1'b1, 32'h200);
        chk("br_pc", pc, 32'h80);
        chk("br_valid", {31'b0, if_id_valid}, 32'h0);
        run(2);

        // misaligned jump target: forced aligned, sticky flag
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h42);
        chk("mis_pc", pc, 32'h40);
        chk("mis_flag", {31'b0, misaligned}, 32'h1);
        run(3);
        chk("mis_sticky", {31'b0, misaligned}, 32'h1);

        // misaligned branch target under stall
        step(1'b0, 1'b1, 1'b1, 32'h103, 1'b0, 32'h0);
        run(1);

        // PC wrap at top of address space
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        run(1);
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_pc4", if_id_pc4, 32'h0);
        chk("wrap_instr", if_id_instr, 32'h5FFF_FFFF);
        run(2);

        // reset mid-stall, then reset with a pending branch
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("rst_stall_cnt", fetch_count, 32'h0);
        chk("rst_stall_mis", {31'b0, misaligned}, 32'h0);
        run(2);
        step(1'b1, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0);
        chk("rst_br_pc", pc, 32'h0);
        run(2);

        if (exp_q.size() != 0) begin
            n_total++;
            $error("FAIL scoreboard_drain: observed %0d entries expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
